fifo_rr_arbiter: RTL and testbench
==================================

// Module: fifo_rr_arbiter
// PURPOSE
// Downstream consumer of NUM_FIFOS fifo instances. Pops 6-bit words from the
// non-empty fifos in round-robin order, one word per cycle. Presents each word
// with a valid strobe and source id to the next stage. Stalls whenever the next
// stage reports almost-full.
// PARAMETERS
// NUM_FIFOS  4  number of upstream fifos; fixed at 4, so the id is 2 bits
// DATA_W     6  word width; matches the fifo data width
// CNT_W      8  width of the transfer counter
// PORTS
// clk          in   1         single clock, rising edge
// RESET_L      in   1         synchronous reset, ACTIVE-HIGH (codebase name)
// fifo_empty   in   4         empty flag per fifo; bit i = fifo i
// fifo_data    in   4*DATA_W  fifo data_out buses; fifo i at [6i+5:6i]
// dn_al_full   in   1         next stage almost full; 1 = do not pop
// dn_full      in   1         next stage full; used only for error detection
// fifo_rd      out  4         one-hot pop strobe to the fifos
// data_out     out  DATA_W    registered output word
// valid_out    out  1         data_out valid, high for 1 cycle per word
// src_id       out  2         fifo index that data_out came from
// err_arb      out  1         sticky overflow error
// xfer_cnt     out  CNT_W     words delivered; saturates at 255
// BEHAVIOUR
// - Reset (RESET_L=1 at a clk edge) forces these values:
//   fifo_rd=0, data_out=0, valid_out=0, src_id=0, err_arb=0, xfer_cnt=0,
//   rr_ptr=0, state=IDLE.
// - Reset wins over every other event. A pop issued in the reset cycle
//   produces no valid_out.
// - FSM states are IDLE, ACTIVE and PAUSE. The state is registered.
//   IDLE->ACTIVE when ~&fifo_empty and ~dn_al_full.
//   IDLE->PAUSE when dn_al_full.
//   ACTIVE->PAUSE when dn_al_full.
//   ACTIVE->IDLE when &fifo_empty and ~dn_al_full.
//   PAUSE->ACTIVE when ~dn_al_full and ~&fifo_empty.
//   PAUSE->IDLE when ~dn_al_full and &fifo_empty.
// - fifo_rd is combinational. It is at most one-hot and never targets a fifo
//   whose empty bit is 1.
// - fifo_rd is nonzero only when next-state logic allows a pop in this cycle:
//   ~dn_al_full and ~RESET_L=0 (not in reset) and some fifo is non-empty.
//   IDLE therefore pops in the same cycle it sees data.
// - Grant search: start at rr_ptr and pick the first non-empty index in the
//   order rr_ptr, rr_ptr+1, ... mod 4.
// - After a grant to index g, rr_ptr <= g+1 mod 4. Without a grant, rr_ptr
//   holds.
// - Read latency is 1. The fifo delivers its word on fifo_data in the cycle
//   after the pop. In that cycle the arbiter registers:
//   data_out <= slice g, src_id <= g, valid_out <= 1.
//   The word becomes visible 1 cycle later, 2 edges after the pop cycle.
// - Back-to-back pops are allowed:
//   - The same fifo may be popped on consecutive cycles when it is the only
//     non-empty fifo.
//   - Its empty flag updates from its registered counter, so a count-1 fifo
//     is not popped twice.
// - dn_al_full high stops new pops in that same cycle. Words already in flight
//   (at most 2) still complete.
// - err_arb is set when valid_out=1 and dn_full=1 in the same cycle. It
//   clears only on reset.
// - xfer_cnt increments on every valid_out and holds at 8'hFF.
// - Because of the mod-4 pointer, wrap-around from index 3 to 0 is seamless.
// TESTING
// 1 Reset: hold RESET_L=1 for 2 cycles with all fifos non-empty ->
//   all outputs 0 and fifo_rd=0 throughout.
// 2 All four fifos hold 2 words, dn_al_full=0 ->
//   fifo_rd = 0001,0010,0100,1000,0001,0010,0100,1000, then 0000.
//   src_id sequence is 0,1,2,3,0,1,2,3. xfer_cnt=8.
// 3 Only fifo 2 holds 3 words (0x15,0x2A,0x3F) ->
//   fifo_rd=0100 for exactly 3 cycles.
//   data_out = 0x15,0x2A,0x3F on consecutive cycles, then IDLE.
// 4 Raise dn_al_full mid-stream after the pop to fifo 1 ->
//   fifo_rd=0 the same cycle, state=PAUSE, at most 2 further valid_out.
//   On release, popping resumes at fifo 2.
// 5 Assert dn_full while valid_out=1 ->
//   err_arb=1 next cycle and stays 1 until reset.
// 6 Stream 260 words -> xfer_cnt saturates at 255.
//   Reset in the middle of the stream -> counter=0, no stray valid_out.

Source files
------------

// File: rtl/fifo_rr_arbiter.sv
`timescale 1ns/1ps
// Round-robin drain of NUM_FIFOS upstream fifos into one word stream with source id.
// Latency: pop issued combinationally; word appears on data_out/valid_out two edges after the pop cycle.
// Backpressure: dn_al_full blocks new pops in the same cycle; up to two in-flight words still complete.
module fifo_rr_arbiter #(
    parameter int NUM_FIFOS = 4,
    parameter int DATA_W    = 6,
    parameter int CNT_W     = 8
) (
    input  logic                        clk,
    input  logic                        RESET_L,
    input  logic [NUM_FIFOS-1:0]        fifo_empty,
    input  logic [NUM_FIFOS*DATA_W-1:0] fifo_data,
    input  logic                        dn_al_full,
    input  logic                        dn_full,
    output logic [NUM_FIFOS-1:0]        fifo_rd,
    output logic [DATA_W-1:0]           data_out,
    output logic                        valid_out,
    output logic [1:0]                  src_id,
    output logic                        err_arb,
    output logic [CNT_W-1:0]            xfer_cnt
);

    localparam int ID_W = $clog2(NUM_FIFOS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        PAUSE  = 2'd2
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic              grant_vld;
    logic [ID_W-1:0]   grant_idx;
    logic              pop_en;
    logic              all_empty;

    // Pop pipeline: which fifo was popped last cycle, so its word can be captured now.
    logic              rd_vld_q;
    logic [ID_W-1:0]   rd_idx_q;

    logic [DATA_W-1:0] words [NUM_FIFOS];

    assign all_empty = &fifo_empty;

    // Split the flat data bus into one word per fifo.
    always_comb begin
        for (int k = 0; k < NUM_FIFOS; k++) begin
            words[k] = fifo_data[k*DATA_W +: DATA_W];
        end
    end

    // Grant search: first non-empty fifo starting at rr_ptr; walking offsets from
    // high to low lets the smallest offset overwrite the others.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr;
        for (int k = NUM_FIFOS-1; k >= 0; k--) begin
            if (!fifo_empty[rr_ptr + ID_W'(k)]) begin
                grant_vld = 1'b1;
                grant_idx = rr_ptr + ID_W'(k);
            end
        end
    end

    // A pop needs data, downstream room and no reset; the state does not gate it,
    // so IDLE pops in the same cycle it first sees data.
    assign pop_en = grant_vld & ~dn_al_full & ~RESET_L;

    // One-hot pop strobe to the granted fifo.
    always_comb begin
        fifo_rd = '0;
        if (pop_en) begin
            fifo_rd[grant_idx] = 1'b1;
        end
    end

    // Control state, tracking whether we are draining, waiting for data or held off.
    always_ff @(posedge clk) begin
        if (RESET_L) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (dn_al_full)      state <= PAUSE;
                    else if (!all_empty) state <= ACTIVE;
                end
                ACTIVE: begin
                    if (dn_al_full)      state <= PAUSE;
                    else if (all_empty)  state <= IDLE;
                end
                PAUSE: begin
                    if (!dn_al_full)     state <= all_empty ? IDLE : ACTIVE;
                end
                default:                 state <= IDLE;
            endcase
        end
    end

    // Advance the pointer past each granted fifo and remember the pop for capture.
    always_ff @(posedge clk) begin
        if (RESET_L) begin
            rr_ptr   <= '0;
            rd_vld_q <= 1'b0;
            rd_idx_q <= '0;
        end else begin
            rd_vld_q <= pop_en;
            rd_idx_q <= grant_idx;
            if (pop_en) begin
                rr_ptr <= grant_idx + ID_W'(1);
            end
        end
    end

    // Capture the word the fifo delivers one cycle after its pop and publish it.
    always_ff @(posedge clk) begin
        if (RESET_L) begin
            data_out  <= '0;
            src_id    <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= rd_vld_q;
            if (rd_vld_q) begin
                data_out <= words[rd_idx_q];
                src_id   <= rd_idx_q;
            end
        end
    end

    // Sticky overflow flag and saturating count of delivered words.
    always_ff @(posedge clk) begin
        if (RESET_L) begin
            err_arb  <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            if (valid_out && dn_full) begin
                err_arb <= 1'b1;
            end
            if (rd_vld_q && (xfer_cnt != {CNT_W{1'b1}})) begin
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
`timescale 1ns/1ps
module tb_fifo_rr_arbiter;

    logic        clk = 1'b0;
    logic        RESET_L;
    logic [3:0]  fe = 4'hF;
    logic [5:0]  fd [4] = '{default: 6'd0};
    logic [23:0] fd_bus;
    logic        dn_al_full;
    logic        dn_full;
    logic [3:0]  fifo_rd;
    logic [5:0]  data_out;
    logic        valid_out;
    logic [1:0]  src_id;
    logic        err_arb;
    logic [7:0]  xfer_cnt;

    typedef struct packed {
        logic [1:0] id;
        logic [5:0] dat;
    } exp_t;

    exp_t       sb [$];
    logic [5:0] fq0 [$];
    logic [5:0] fq1 [$];
    logic [5:0] fq2 [$];
    logic [5:0] fq3 [$];
    logic       sb_drop = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    assign fd_bus = {fd[3], fd[2], fd[1], fd[0]};

    fifo_rr_arbiter dut (
        .clk        (clk),
        .RESET_L    (RESET_L),
        .fifo_empty (fe),
        .fifo_data  (fd_bus),
        .dn_al_full (dn_al_full),
        .dn_full    (dn_full),
        .fifo_rd    (fifo_rd),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .src_id     (src_id),
        .err_arb    (err_arb),
        .xfer_cnt   (xfer_cnt)
    );

    function automatic int qsize(input int i);
        case (i)
            0: return fq0.size();
            1: return fq1.size();
            2: return fq2.size();
            default: return fq3.size();
        endcase
    endfunction

    function automatic logic [5:0] qpop(input int i);
        logic [5:0] w;
        w = '0;
        case (i)
            0: w = fq0.pop_front();
            1: w = fq1.pop_front();
            2: w = fq2.pop_front();
            default: w = fq3.pop_front();
        endcase
        return w;
    endfunction

    task automatic load(input int i, input logic [5:0] w);
        case (i)
            0: fq0.push_back(w);
            1: fq1.push_back(w);
            2: fq2.push_back(w);
            default: fq3.push_back(w);
        endcase
    endtask

    task automatic expect_w(input int id, input logic [5:0] w);
        exp_t e;
        e.id  = id[1:0];
        e.dat = w;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic drain(input string name, input int bound);
        for (int c = 0; c < bound && sb.size() != 0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk(name, sb.size(), 0);
    endtask

    // Upstream fifo models: read latency 1, empty flag from registered occupancy.
    always @(posedge clk) begin
        if (!$onehot0(fifo_rd) || ((fifo_rd & fe) != 4'b0)) begin
            n_err++;
            $display("FAIL rd_legal: fifo_rd=%b empty=%b, required one-hot to a non-empty fifo", fifo_rd, fe);
        end
        for (int i = 0; i < 4; i++) begin
            if (fifo_rd[i] && qsize(i) != 0) begin
                logic [5:0] w;
                w = qpop(i);
                fd[i] <= w;
            end
        end
        for (int i = 0; i < 4; i++) begin
            fe[i] <= (qsize(i) == 0);
        end
    end

    // Scoreboard monitor: every delivered word must match the next expected one.
    always @(negedge clk) begin
        if (valid_out) begin
            if (sb_drop) begin
                if (sb.size() != 0) sb.delete(0);
            end else if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL stray_valid: got id=%0d data=0x%0h, required no valid_out", src_id, data_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_cmp++;
                if ({src_id, data_out} !== e) begin
                    n_err++;
                    $display("FAIL word: got id=%0d data=0x%0h, required id=%0d data=0x%0h",
                             src_id, data_out, e.id, e.dat);
                end
            end
        end
    end

    initial begin
        logic [3:0] t2_rd  [9];
        logic       t2_vld [9];
        logic [3:0] t3_rd  [6];
        logic       t3_vld [6];
        logic [3:0] t4_rd  [6];
        int         nv;
        int         seen;

        t2_rd  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        t2_vld = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        t3_rd  = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        t3_vld = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        t4_rd  = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0000};

        RESET_L    = 1'b1;
        dn_al_full = 1'b0;
        dn_full    = 1'b0;

        // 1: reset held with every fifo loaded (the load is also the data for test 2)
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            load(i, 6'(1 + i));
            load(i, 6'(5 + i));
        end
        expect_w(0, 6'h01); expect_w(1, 6'h02); expect_w(2, 6'h03); expect_w(3, 6'h04);
        expect_w(0, 6'h05); expect_w(1, 6'h06); expect_w(2, 6'h07); expect_w(3, 6'h08);
        repeat (2) begin
            @(negedge clk); #1;
            chk("rst_fifo_rd", fifo_rd, 0);
            chk("rst_outputs", {data_out, valid_out, src_id, err_arb, xfer_cnt}, 0);
        end

        // 2: two words per fifo, strict rotation, first word two edges after its pop
        @(negedge clk);
        RESET_L = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            chk("t2_fifo_rd", fifo_rd, t2_rd[k]);
            chk("t2_valid", valid_out, t2_vld[k]);
        end
        drain("t2_drain", 20);
        chk("t2_xfer_cnt", xfer_cnt, 8);

        // 3: only fifo 2 has data, popped back to back exactly three times
        @(negedge clk);
        load(2, 6'h15); load(2, 6'h2A); load(2, 6'h3F);
        expect_w(2, 6'h15); expect_w(2, 6'h2A); expect_w(2, 6'h3F);
        #1;
        chk("t3_fifo_rd_load", fifo_rd, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            chk("t3_fifo_rd", fifo_rd, t3_rd[k]);
            chk("t3_valid", valid_out, t3_vld[k]);
        end
        drain("t3_drain", 10);
        chk("t3_xfer_cnt", xfer_cnt, 11);

        // 4: almost-full after the grant to fifo 1, resume at fifo 2
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            load(i, 6'(8'h20 + i));
            load(i, 6'(8'h28 + i));
        end
        expect_w(3, 6'h23); expect_w(0, 6'h20); expect_w(1, 6'h21);
        expect_w(2, 6'h22); expect_w(3, 6'h2B); expect_w(0, 6'h28);
        expect_w(1, 6'h29); expect_w(2, 6'h2A);
        #1;
        chk("t4_fifo_rd_load", fifo_rd, 0);
        @(negedge clk); #1; chk("t4_rd_f3", fifo_rd, 4'b1000);
        @(negedge clk); #1; chk("t4_rd_f0", fifo_rd, 4'b0001);
        @(negedge clk); #1; chk("t4_rd_f1", fifo_rd, 4'b0010);
        nv = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) dn_al_full = 1'b1;
            #1;
            chk("t4_pause_rd", fifo_rd, 0);
            if (valid_out) nv++;
        end
        chk("t4_inflight", nv, 2);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) dn_al_full = 1'b0;
            #1;
            chk("t4_resume_rd", fifo_rd, t4_rd[k]);
        end
        drain("t4_drain", 20);
        chk("t4_xfer_cnt", xfer_cnt, 19);

        // 5: dn_full alone is harmless; dn_full with valid_out latches err_arb
        @(negedge clk); dn_full = 1'b1;
        @(negedge clk); dn_full = 1'b0; #1;
        chk("t5_err_idle", err_arb, 0);
        load(0, 6'h11);
        expect_w(0, 6'h11);
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            if (valid_out) seen = 1;
        end
        chk("t5_valid_seen", seen, 1);
        dn_full = 1'b1;
        @(negedge clk);
        dn_full = 1'b0;
        #1;
        chk("t5_err_set", err_arb, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("t5_err_sticky", err_arb, 1);
        chk("t5_xfer_cnt", xfer_cnt, 20);

        // 6: 260 more words saturate the counter at 255
        @(negedge clk);
        for (int k = 0; k < 260; k++) begin
            load((1 + k) % 4, 6'(k));
            expect_w((1 + k) % 4, 6'(k));
        end
        drain("t6_drain", 400);
        chk("t6_xfer_sat", xfer_cnt, 8'hFF);
        chk("t6_err_still", err_arb, 1);

        // 6b: reset in the middle of a stream
        @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            load((1 + k) % 4, 6'(k + 3));
            expect_w((1 + k) % 4, 6'(k + 3));
        end
        repeat (10) @(negedge clk);
        sb_drop = 1'b1;
        RESET_L = 1'b1;
        #1;
        chk("t6_rst_rd", fifo_rd, 0);
        fq0.delete(); fq1.delete(); fq2.delete(); fq3.delete();
        sb.delete();
        @(negedge clk); #1;
        chk("t6_rst_rd2", fifo_rd, 0);
        chk("t6_rst_outputs", {valid_out, err_arb, xfer_cnt}, 0);
        @(negedge clk);
        RESET_L = 1'b0;
        sb_drop = 1'b0;
        #1;
        chk("t6_post_rd", fifo_rd, 0);
        nv = 0;
        repeat (6) begin
            @(negedge clk); #1;
            if (valid_out) nv++;
        end
        chk("t6_no_stray", nv, 0);
        chk("t6_cnt_zero", xfer_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
